ahb_lite_cmd_master: RTL and testbench
======================================

// Module: ahb_lite_cmd_master
// PURPOSE
//  AHB-Lite bus master driven by a byte-stream command channel, typically fed by a UART
//  receiver FIFO. It is the initiator counterpart of the AHB-Lite UART16550 slave.
//  It parses read/write commands, issues single 32-bit AHB-Lite transfers and returns
//  status/read data as bytes. Used as a host debug/boot path onto the system bus.
// PARAMETERS
//  WR_CMD    8'h57  command byte: write word
//  RD_CMD    8'h52  command byte: read word
//  ACK_BYTE  8'h2B  status byte: transfer OK ('+')
//  ERR_BYTE  8'h21  status byte: HRESP error ('!')
//  BAD_BYTE  8'h3F  status byte: unknown command ('?')
// PORTS
//  HCLK       in   1   clock
//  HRESET     in   1   reset
//  RX_DATA    in   8   command byte in
//  RX_VALID   in   1   RX_DATA valid
//  RX_READY   out  1   block accepts RX_DATA this cycle
//  TX_DATA    out  8   response byte out
//  TX_VALID   out  1   TX_DATA valid
//  TX_READY   in   1   sink accepts TX_DATA
//  HADDR      out  32  AHB address
//  HBURST     out  3   constant 3'b000 (SINGLE)
//  HMASTLOCK  out  1   constant 0
//  HPROT      out  4   constant 4'b0011
//  HSIZE      out  3   constant 3'b010 (word)
//  HTRANS     out  2   2'b00 IDLE / 2'b10 NONSEQ
//  HWRITE     out  1   transfer direction
//  HWDATA     out  32  write data
//  HRDATA     in   32  read data
//  HREADY     in   1   bus ready (transfer complete / address accepted)
//  HRESP      in   1   1 = error response
//  BUSY       out  1   high in every state except S_CMD
// BEHAVIOUR
//  Clocking/reset: one clock; reset is synchronous and active-high.
//  - Reset values: state S_CMD; HTRANS=IDLE; HADDR, HWDATA, HWRITE, TX_DATA, TX_VALID = 0.
//  - RX_READY=0 while HRESET=1.
//  - Reset mid-operation: at the next edge, outputs go idle and partial command and
//    response are discarded.
//  Handshakes:
//  - A byte is taken when RX_VALID&&RX_READY.
//  - TX_DATA/TX_VALID are held stable until TX_VALID&&TX_READY.
//  Command format (all multi-byte fields MSB first):
//  - Write: WR_CMD, A3..A0, D3..D0.
//  - Read: RD_CMD, A3..A0.
//  - HADDR[1:0] is forced to 2'b00.
//  FSM:
//  - S_CMD: RX_READY=1.
//    - WR_CMD/RD_CMD -> S_ADDR; latch HWRITE.
//    - Other byte -> S_STAT with BAD_BYTE.
//  - S_ADDR: RX_READY=1; 4 bytes shift into the address register.
//    - After the 4th byte: write -> S_WDATA, read -> S_APH.
//  - S_WDATA: RX_READY=1; 4 bytes shift into the data register; then -> S_APH.
//  - S_APH (entered the cycle after the last command byte):
//    - Drive HTRANS=NONSEQ, HADDR, HWRITE; hold them until an edge with HREADY=1.
//    - On that edge -> S_DPH.
//  - S_DPH:
//    - Drive HTRANS=IDLE; HWDATA carries write data from entry until completion.
//    - Completion is the first edge with HREADY=1.
//    - At completion: capture HRDATA and record err=HRESP, then -> S_STAT.
//    - The 2-cycle error (HRESP=1, HREADY=0 then HRESP=1, HREADY=1) completes with err=1.
//  - S_STAT:
//    - TX_VALID=1; TX_DATA = ERR_BYTE if err, ACK_BYTE if OK, BAD_BYTE for an unknown
//      command.
//    - On handshake: OK read -> S_RDATA; otherwise -> S_CMD.
//  - S_RDATA: send the captured read word as 4 bytes, MSB first; after the 4th handshake
//    -> S_CMD.
//  Latency (zero wait states):
//  - Last command byte at edge N; NONSEQ during cycle N+1; data phase during N+2.
//  - TX_VALID for the status byte rises in cycle N+3.
//  Boundary conditions:
//  - Only one transfer is ever outstanding; no pipelining and no bursts.
//  - HTRANS is never BUSY/SEQ.
//  - RX bytes are not accepted from S_APH through the last response byte (RX_READY=0).
//  - Byte counters wrap 3->0 at each field end.
//  - No timeout: the block waits indefinitely for HREADY.
// TESTING
//  1. Send 57 10 00 00 04 DE AD BE EF, zero-wait slave:
//     HADDR=0x10000004, HWRITE=1, HWDATA=0xDEADBEEF in data phase; TX emits 2B.
//  2. Send 52 10 00 00 08, slave returns 0x12345678 after 3 wait states:
//     NONSEQ held one cycle; TX emits 2B 12 34 56 78.
//  3. Read with a 2-cycle HRESP error: TX emits 21 only; next command is accepted.
//  4. Send 0x00 then 52 ...: TX emits 3F with no bus activity; the following read
//     executes normally.
//  5. Hold TX_READY=0 for 10 cycles during the read response: TX_DATA stable, no bytes
//     lost or duplicated.
//  6. Assert HRESET during S_DPH: next cycle HTRANS=IDLE, TX_VALID=0; block accepts a
//     new command afterwards.

Source files
------------

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer master driven by a byte command stream.
// Write command: WR_CMD, A3..A0, D3..D0. Read command: RD_CMD, A3..A0.
// The status byte comes back first; a successful read then returns its word, MSB first.
//
// Handshake rule for both byte channels: a byte moves on a rising edge where
// valid && ready. The producer holds data/valid stable until that edge, and
// ready may depend combinationally on state and reset only.
module ahb_lite_cmd_master #(
  parameter logic [7:0] WR_CMD   = 8'h57,
  parameter logic [7:0] RD_CMD   = 8'h52,
  parameter logic [7:0] ACK_BYTE = 8'h2B,
  parameter logic [7:0] ERR_BYTE = 8'h21,
  parameter logic [7:0] BAD_BYTE = 8'h3F
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_APH   = 3'd3,
    S_DPH   = 3'd4,
    S_STAT  = 3'd5,
    S_RDATA = 3'd6
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  state_t      state;
  state_t      state_next;
  logic [1:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        is_write;
  logic        err;
  logic        bad;
  logic        rx_fire;
  logic        tx_fire;
  logic        is_known_cmd;

  assign rx_fire      = RX_VALID && RX_READY;
  assign tx_fire      = TX_VALID && TX_READY;
  assign is_known_cmd = (RX_DATA == WR_CMD) || (RX_DATA == RD_CMD);

  // Attributes that never change: single word, non-locked, privileged data access.
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = 4'b0011;
  assign HSIZE     = 3'b010;

  // Address and write data come straight from their shift registers; the
  // address is word aligned regardless of the low bits the host sent.
  assign HADDR  = {addr_q[31:2], 2'b00};
  assign HWDATA = wdata_q;
  assign HWRITE = is_write;

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_CMD;
    else        state <= state_next;
  end

  // Next-state decode and state-driven outputs.
  always_comb begin
    state_next = state;
    RX_READY   = 1'b0;
    TX_VALID   = 1'b0;
    TX_DATA    = 8'h00;
    HTRANS     = TRANS_IDLE;
    BUSY       = (state != S_CMD);
    case (state)
      S_CMD: begin
        RX_READY = !HRESET;
        if (rx_fire) state_next = is_known_cmd ? S_ADDR : S_STAT;
      end
      S_ADDR: begin
        RX_READY = !HRESET;
        if (rx_fire && cnt == 2'd3) state_next = is_write ? S_WDATA : S_APH;
      end
      S_WDATA: begin
        RX_READY = !HRESET;
        if (rx_fire && cnt == 2'd3) state_next = S_APH;
      end
      S_APH: begin
        HTRANS = TRANS_NONSEQ;
        if (HREADY) state_next = S_DPH;
      end
      S_DPH: begin
        if (HREADY) state_next = S_STAT;
      end
      S_STAT: begin
        TX_VALID = 1'b1;
        TX_DATA  = bad ? BAD_BYTE : (err ? ERR_BYTE : ACK_BYTE);
        if (tx_fire) state_next = (!bad && !err && !is_write) ? S_RDATA : S_CMD;
      end
      S_RDATA: begin
        TX_VALID = 1'b1;
        case (cnt)
          2'd0:    TX_DATA = rdata_q[31:24];
          2'd1:    TX_DATA = rdata_q[23:16];
          2'd2:    TX_DATA = rdata_q[15:8];
          default: TX_DATA = rdata_q[7:0];
        endcase
        if (tx_fire && cnt == 2'd3) state_next = S_CMD;
      end
      default: state_next = S_CMD;
    endcase
  end

  // Command parsing, field shifting, byte counting and response capture.
  // The 2-bit counter wraps 3->0 at the end of every field, so each field
  // starts at zero without an explicit clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cnt      <= 2'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      is_write <= 1'b0;
      err      <= 1'b0;
      bad      <= 1'b0;
    end else begin
      case (state)
        S_CMD: begin
          if (rx_fire) begin
            is_write <= (RX_DATA == WR_CMD);
            bad      <= !is_known_cmd;
            err      <= 1'b0;
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_q <= {addr_q[23:0], RX_DATA};
            cnt    <= cnt + 2'd1;
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            wdata_q <= {wdata_q[23:0], RX_DATA};
            cnt     <= cnt + 2'd1;
          end
        end
        S_DPH: begin
          if (HREADY) begin
            rdata_q <= HRDATA;
            err     <= HRESP;
          end
        end
        S_RDATA: begin
          if (tx_fire) cnt <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed testbench for ahb_lite_cmd_master: the bench plays both the host
// byte source/sink and a single AHB-Lite slave with programmable wait states
// and error responses. Inputs change and outputs are sampled on the falling edge.
module tb_ahb_lite_cmd_master;

  logic        HCLK;
  logic        HRESET;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        BUSY;

  int n_total = 0;
  int n_pass  = 0;
  int ns_count = 0;

  ahb_lite_cmd_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .BUSY(BUSY)
  );

  // Clock and reset-free clock generation.
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Count every cycle the master drives NONSEQ onto the bus.
  always @(posedge HCLK) if (HTRANS == 2'b10) ns_count <= ns_count + 1;

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  // Offer one command byte and wait for it to be accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    n = 0;
    while (!RX_READY && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    if (!RX_READY) check("rx_ready_timeout", 32'(RX_READY), 32'd1);
    @(negedge HCLK);
    RX_VALID = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [31:0] a);
    send_byte(c);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  // Wait for a response byte, compare it, then take it.
  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int n;
    TX_READY = 1'b1;
    n = 0;
    while (!TX_VALID && n < 100) begin
      @(negedge HCLK);
      n++;
    end
    check(tag, {24'h0, TX_DATA}, {24'h0, exp});
    @(negedge HCLK);
    TX_READY = 1'b0;
  endtask

  // Serve one transfer as the slave. Called right after the last command
  // byte's edge; nonseq must already be on the bus (one-cycle latency).
  task automatic bus_xfer(input string tag, input int waits, input logic err,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic exp_write, input logic [31:0] exp_wdata);
    int n;
    check({tag, "_nonseq_now"}, 32'(HTRANS), 32'h2);
    n = 0;
    while (HTRANS != 2'b10 && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check({tag, "_haddr"}, HADDR, exp_addr);
    check({tag, "_hwrite"}, 32'(HWRITE), 32'(exp_write));
    n = 0;
    while (HTRANS == 2'b10 && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check({tag, "_nonseq_cycles"}, 32'(n), 32'd1);
    check({tag, "_dph_idle"}, 32'(HTRANS), 32'h0);
    if (exp_write) check({tag, "_hwdata"}, HWDATA, exp_wdata);
    for (int i = 0; i < waits; i++) begin
      HREADY = 1'b0;
      HRESP  = err && (i == waits - 1);
      @(negedge HCLK);
    end
    HREADY = 1'b1;
    HRESP  = err;
    HRDATA = rdata;
    @(negedge HCLK);
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    check({tag, "_stat_latency"}, 32'(TX_VALID), 32'd1);
  endtask

  initial begin
    logic stable;
    int   ns_before;
    HRESET   = 1'b1;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    TX_READY = 1'b0;
    HRDATA   = 32'h0;
    HREADY   = 1'b1;
    HRESP    = 1'b0;
    repeat (3) @(negedge HCLK);

    // Reset state.
    check("rst_htrans",   32'(HTRANS), 32'h0);
    check("rst_haddr",    HADDR, 32'h0);
    check("rst_hwdata",   HWDATA, 32'h0);
    check("rst_hwrite",   32'(HWRITE), 32'h0);
    check("rst_tx_valid", 32'(TX_VALID), 32'h0);
    check("rst_rx_ready", 32'(RX_READY), 32'h0);
    check("rst_busy",     32'(BUSY), 32'h0);
    check("const_attrs",  {19'h0, HBURST, HMASTLOCK, HPROT, HSIZE}, {19'h0, 3'b000, 1'b0, 4'b0011, 3'b010});
    HRESET = 1'b0;
    @(negedge HCLK);
    check("idle_rx_ready", 32'(RX_READY), 32'h1);

    // 1: zero-wait write.
    send_cmd(8'h57, 32'h1000_0004);
    for (int i = 3; i >= 0; i--) send_byte(8'(32'hDEAD_BEEF >> (i * 8)));
    bus_xfer("t1", 0, 1'b0, 32'h0, 32'h1000_0004, 1'b1, 32'hDEAD_BEEF);
    check("t1_rx_blocked", 32'(RX_READY), 32'h0);
    recv_byte("t1_status", 8'h2B);
    check("t1_idle", 32'(BUSY), 32'h0);

    // 2: read with three wait states.
    send_cmd(8'h52, 32'h1000_0008);
    bus_xfer("t2", 3, 1'b0, 32'h1234_5678, 32'h1000_0008, 1'b0, 32'h0);
    recv_byte("t2_status", 8'h2B);
    recv_byte("t2_b3", 8'h12);
    recv_byte("t2_b2", 8'h34);
    recv_byte("t2_b1", 8'h56);
    recv_byte("t2_b0", 8'h78);
    check("t2_idle", 32'(BUSY), 32'h0);

    // 3: read ending in a two-cycle error; only the error byte comes back.
    send_cmd(8'h52, 32'h1000_000C);
    bus_xfer("t3", 1, 1'b1, 32'hFFFF_FFFF, 32'h1000_000C, 1'b0, 32'h0);
    recv_byte("t3_status", 8'h21);
    check("t3_no_data", 32'(TX_VALID), 32'h0);
    check("t3_idle", 32'(BUSY), 32'h0);

    // 4: unknown command, no bus traffic; then a read with unaligned address bits.
    ns_before = ns_count;
    send_byte(8'h00);
    recv_byte("t4_bad", 8'h3F);
    check("t4_no_bus", 32'(ns_count - ns_before), 32'h0);
    check("t4_idle", 32'(BUSY), 32'h0);
    send_cmd(8'h52, 32'h2000_000F);
    bus_xfer("t4", 0, 1'b0, 32'hCAFE_F00D, 32'h2000_000C, 1'b0, 32'h0);
    recv_byte("t4_status", 8'h2B);
    recv_byte("t4_b3", 8'hCA);
    recv_byte("t4_b2", 8'hFE);
    recv_byte("t4_b1", 8'hF0);
    recv_byte("t4_b0", 8'h0D);

    // 5: sink stalls for ten cycles mid-response.
    send_cmd(8'h52, 32'h3000_0000);
    bus_xfer("t5", 0, 1'b0, 32'hA5C3_1E77, 32'h3000_0000, 1'b0, 32'h0);
    recv_byte("t5_status", 8'h2B);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (TX_DATA !== 8'hA5 || TX_VALID !== 1'b1 || RX_READY !== 1'b0) stable = 1'b0;
    end
    check("t5_stall_stable", 32'(stable), 32'h1);
    recv_byte("t5_b3", 8'hA5);
    recv_byte("t5_b2", 8'hC3);
    recv_byte("t5_b1", 8'h1E);
    recv_byte("t5_b0", 8'h77);
    check("t5_idle", 32'(BUSY), 32'h0);

    // 6: reset while the data phase is stalled.
    send_cmd(8'h57, 32'h4000_0010);
    for (int i = 3; i >= 0; i--) send_byte(8'h55);
    check("t6_nonseq", 32'(HTRANS), 32'h2);
    @(negedge HCLK);
    HREADY = 1'b0;
    check("t6_in_dph", 32'(HTRANS), 32'h0);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("t6_rst_htrans", 32'(HTRANS), 32'h0);
    check("t6_rst_txv", 32'(TX_VALID), 32'h0);
    check("t6_rst_busy", 32'(BUSY), 32'h0);
    check("t6_rst_haddr", HADDR, 32'h0);
    HRESET = 1'b0;
    HREADY = 1'b1;
    @(negedge HCLK);
    send_cmd(8'h57, 32'h4000_0000);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    bus_xfer("t6", 0, 1'b0, 32'h0, 32'h4000_0000, 1'b1, 32'h0102_0304);
    recv_byte("t6_status", 8'h2B);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so a stuck design cannot hang the run.
  initial begin
    #200000;
    check("global_timeout", 32'h0, 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
